// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronizer, N x tick generator, 3-sample majority vote,
// optional parity, 1 or 2 stop bits, with parity/framing/break flags qualifying each ready pulse.
module uart_rx_os #(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned BAUDRATE      = 9600,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BIT_SIZE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] receive_data,
    output logic                  ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  busy
);
    localparam int unsigned DIV   = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
    localparam int unsigned M     = OVERSAMPLE / 2;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W   = $clog2(OVERSAMPLE);
    localparam int unsigned B_W   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT
    } state_t;

    state_t                state;
    logic                  sync1;
    logic                  rx;
    logic                  rx_prev;
    logic [DIV_W-1:0]      tick_cnt;
    logic [S_W-1:0]        s;
    logic                  v0;
    logic                  v1;
    logic [DATA_WIDTH-1:0] shift;
    logic [B_W-1:0]        bit_cnt;
    logic                  stop_cnt;
    logic                  perr;
    logic                  ferr;
    logic                  tail_zero;

    logic tick;
    logic wrap;
    logic decide;
    logic fall;
    logic start;
    logic maj;
    logic exp_par;
    logic fe_now;
    logic last_stop;

    assign fall      = rx_prev & ~rx;
    assign start     = (state == S_IDLE) && fall;
    assign tick      = (tick_cnt == DIV_W'(DIV - 1));
    assign wrap      = tick && (s == S_W'(OVERSAMPLE - 1));
    assign decide    = tick && (s == S_W'(M + 1));
    assign maj       = (v0 & v1) | (v0 & rx) | (v1 & rx);
    assign exp_par   = (PARITY == 1) ? ^shift : ~^shift;
    assign fe_now    = ferr | ~maj;
    assign last_stop = (stop_cnt == 1'(STOP_BIT_SIZE - 1));

    // Synchronizer and edge flops idle high so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx      <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= line;
            rx      <= sync1;
            rx_prev <= rx;
        end
    end

    // Tick divider and sample counter, both realigned to the detected start edge.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            tick_cnt <= '0;
            s        <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            s        <= wrap ? '0 : s + 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Frame FSM; each bit is decided on the third vote tick, and the frame completes
    // at the last stop decision so the next start edge can be caught immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            receive_data <= '0;
            ready        <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
            busy         <= 1'b0;
            v0           <= 1'b1;
            v1           <= 1'b1;
            shift        <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            tail_zero    <= 1'b0;
        end else begin
            ready      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;

            if (tick && (s == S_W'(M - 1))) v0 <= rx;
            if (tick && (s == S_W'(M)))     v1 <= rx;

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state     <= S_START;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        perr      <= 1'b0;
                        ferr      <= 1'b0;
                        tail_zero <= 1'b1;
                    end
                end
                S_START: begin
                    if (decide && maj) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (wrap) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        shift   <= {maj, shift[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == B_W'(DATA_WIDTH - 1)) begin
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end
                    end
                end
                S_PAR: begin
                    if (decide) begin
                        perr      <= (maj != exp_par);
                        tail_zero <= tail_zero & ~maj;
                        state     <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (decide) begin
                        if (last_stop) begin
                            receive_data <= shift;
                            ready        <= 1'b1;
                            parity_err   <= (PARITY != 0) && perr;
                            frame_err    <= fe_now;
                            break_det    <= (shift == '0) && tail_zero && !maj;
                            state        <= fe_now ? S_WAIT : S_IDLE;
                            busy         <= fe_now;
                        end else begin
                            ferr      <= fe_now;
                            tail_zero <= tail_zero & ~maj;
                            stop_cnt  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (rx) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1, 8E1 and 8N2 receivers at 160 clocks per bit.
module tb_uart_rx_os;
    localparam int unsigned CLK_FREQ = 1600000;
    localparam int unsigned BAUD     = 10000;
    localparam int unsigned BITCLK   = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] line_v = 3'b111;
    logic [2:0] rdy, pe, fe, bd, bsy;
    logic [7:0] rd0, rd1, rd2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int leak = 0;
    int rcnt [3];
    int rcyc [3];
    logic [7:0] rdat [3];
    logic rpe [3];
    logic rfe [3];
    logic rbd [3];
    logic rbusy [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .OVERSAMPLE(16), .DATA_WIDTH(8),
                 .PARITY(0), .STOP_BIT_SIZE(1)) u_8n1 (
        .clk(clk), .reset(reset), .line(line_v[0]), .receive_data(rd0), .ready(rdy[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bd[0]), .busy(bsy[0]));
    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .OVERSAMPLE(16), .DATA_WIDTH(8),
                 .PARITY(1), .STOP_BIT_SIZE(1)) u_8e1 (
        .clk(clk), .reset(reset), .line(line_v[1]), .receive_data(rd1), .ready(rdy[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bd[1]), .busy(bsy[1]));
    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .OVERSAMPLE(16), .DATA_WIDTH(8),
                 .PARITY(0), .STOP_BIT_SIZE(2)) u_8n2 (
        .clk(clk), .reset(reset), .line(line_v[2]), .receive_data(rd2), .ready(rdy[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bd[2]), .busy(bsy[2]));

    // Capture every ready pulse; any flag outside a ready cycle is counted as a leak.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rdy[i]) begin
                rcnt[i]  = rcnt[i] + 1;
                rcyc[i]  = cyc;
                rdat[i]  = (i == 0) ? rd0 : (i == 1) ? rd1 : rd2;
                rpe[i]   = pe[i];
                rfe[i]   = fe[i];
                rbd[i]   = bd[i];
                rbusy[i] = bsy[i];
            end else if (pe[i] | fe[i] | bd[i]) begin
                leak = leak + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] frame(input logic [7:0] d, input int par, input logic flip,
                                          input int nstop, input logic stopv);
        logic [15:0] f;
        int k;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        k = 9;
        if (par != 0) begin
            f[k] = ((par == 1) ? ^d : ~^d) ^ flip;
            k++;
        end
        for (int i = 0; i < nstop; i++) f[k+i] = stopv;
        return f;
    endfunction

    task automatic send(input int idx, input logic [15:0] fr, input int nb, output int n);
        @(posedge clk); #1;
        n = cyc;
        for (int b = 0; b < nb; b++) begin
            line_v[idx] = fr[b];
            repeat (BITCLK) @(posedge clk);
            #1;
        end
        line_v[idx] = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input int idx, input int n, input int c0,
                                input int off, input logic [7:0] d, input logic epe,
                                input logic efe, input logic ebd, input logic ebusy);
        chk({tag, "_count"}, 32'(rcnt[idx]), 32'(c0 + 1));
        chk({tag, "_cycle"}, 32'(rcyc[idx]), 32'(n + off));
        chk({tag, "_data"},  32'(rdat[idx]), 32'(d));
        chk({tag, "_perr"},  32'(rpe[idx]),  32'(epe));
        chk({tag, "_ferr"},  32'(rfe[idx]),  32'(efe));
        chk({tag, "_brk"},   32'(rbd[idx]),  32'(ebd));
        chk({tag, "_busy"},  32'(rbusy[idx]), 32'(ebusy));
    endtask

    initial begin
        int n;
        int c;
        for (int i = 0; i < 3; i++) begin
            rcnt[i] = 0; rcyc[i] = 0; rdat[i] = '0;
            rpe[i] = 1'b0; rfe[i] = 1'b0; rbd[i] = 1'b0; rbusy[i] = 1'b0;
        end

        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_flags", 32'({pe, fe, bd}), 32'd0);
        chk("rst_busy",  32'(bsy), 32'd0);
        chk("rst_data",  32'({rd0, rd1, rd2}), 32'd0);
        repeat (20) @(posedge clk);

        // 8N1 0xA5: ready at D+1541 = send cycle + 1543
        c = rcnt[0];
        send(0, frame(8'hA5, 0, 1'b0, 1, 1'b1), 10, n);
        repeat (20) @(posedge clk); #1;
        expect_frame("t1", 0, n, c, 1543, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_busy_after", 32'(bsy[0]), 32'd0);

        // 8E1 0x3C good parity, then flipped parity; 11 bits -> offset 1703
        c = rcnt[1];
        send(1, frame(8'h3C, 1, 1'b0, 1, 1'b1), 11, n);
        repeat (20) @(posedge clk); #1;
        expect_frame("t2a", 1, n, c, 1703, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        c = rcnt[1];
        send(1, frame(8'h3C, 1, 1'b1, 1, 1'b1), 11, n);
        repeat (20) @(posedge clk); #1;
        expect_frame("t2b", 1, n, c, 1703, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

        // 3-clock glitch starts a frame that the start-bit vote rejects
        c = rcnt[0];
        @(posedge clk); #1 line_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 line_v[0] = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("t3_glitch_busy", 32'(bsy[0]), 32'd1);
        repeat (300) @(posedge clk); #1;
        chk("t3_glitch_idle", 32'(bsy[0]), 32'd0);
        chk("t3_glitch_noready", 32'(rcnt[0]), 32'(c));
        send(0, frame(8'h55, 0, 1'b0, 1, 1'b1), 10, n);
        repeat (20) @(posedge clk); #1;
        expect_frame("t3", 0, n, c, 1543, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);

        // 0x81 with a low stop bit: framing error, busy held through WAIT_IDLE
        c = rcnt[0];
        send(0, frame(8'h81, 0, 1'b0, 1, 1'b0), 10, n);
        #1;
        chk("t4_wait_busy", 32'(bsy[0]), 32'd1);
        repeat (5) @(posedge clk); #1;
        expect_frame("t4", 0, n, c, 1543, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_busy_after", 32'(bsy[0]), 32'd0);
        c = rcnt[0];
        send(0, frame(8'h7E, 0, 1'b0, 1, 1'b1), 10, n);
        repeat (20) @(posedge clk); #1;
        expect_frame("t4b", 0, n, c, 1543, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);

        // 8N2 break: line low for 30 bit times gives exactly one flagged frame
        c = rcnt[2];
        @(posedge clk); #1;
        n = cyc;
        line_v[2] = 1'b0;
        repeat (30 * BITCLK) @(posedge clk);
        #1;
        expect_frame("t5", 2, n, c, 1703, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5_held_busy", 32'(bsy[2]), 32'd1);
        line_v[2] = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("t5_release_busy", 32'(bsy[2]), 32'd0);
        chk("t5_single_ready", 32'(rcnt[2]), 32'(c + 1));
        c = rcnt[2];
        send(2, frame(8'h11, 0, 1'b0, 2, 1'b1), 11, n);
        repeat (20) @(posedge clk); #1;
        expect_frame("t5b", 2, n, c, 1703, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during the high data bits of 0xF0 aborts the frame silently
        c = rcnt[0];
        send(0, frame(8'hF0, 0, 1'b0, 1, 1'b1), 7, n);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6_rst_ready", 32'(rdy), 32'd0);
        chk("t6_rst_flags", 32'({pe, fe, bd}), 32'd0);
        chk("t6_rst_busy",  32'(bsy), 32'd0);
        chk("t6_rst_data",  32'(rd0), 32'd0);
        repeat (400) @(posedge clk); #1;
        chk("t6_noready", 32'(rcnt[0]), 32'(c));
        send(0, frame(8'h0F, 0, 1'b0, 1, 1'b1), 10, n);
        repeat (20) @(posedge clk); #1;
        expect_frame("t6", 0, n, c, 1543, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);

        chk("flag_leak", 32'(leak), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver: the parametrised successor to the project's basic single-sample receiver. It recovers frames from an asynchronous RX line using an N× oversampling tick, 3-sample majority voting, optional parity and 1 or 2 stop bits. It reports parity, framing and break conditions alongside the data. It sits between the board RX pin and any byte consumer (loopback, display, command decoder), entirely in the `clk` domain.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency, Hz.
- `BAUDRATE`, 9600: line bit rate.
- `OVERSAMPLE`, 16: ticks per bit. Even, ≥ 8.
- `DATA_WIDTH`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOP_BIT_SIZE`, 1: 1 or 2.
- `clk` input 1: system clock. Sole clock of the block.
- `reset` input 1: synchronous, active-high reset.
- `line` input 1: raw asynchronous RX line, idle high.
- `receive_data` output DATA_WIDTH: last received frame payload.
- `ready` output 1: one-cycle pulse, frame complete.
- `parity_err` output 1: qualifies `ready`; parity mismatch.
- `frame_err` output 1: qualifies `ready`; a stop bit sampled 0.
- `break_det` output 1: qualifies `ready`; all data bits, the parity bit and the stop bits are 0.
- `busy` output 1: high whenever the FSM is not IDLE.

## Operation
- Input path: 2-flop synchronizer, then one edge register.
  - Synchronizer and edge flops reset to 1, so no false start occurs at reset release.
  - The synchronized value is `rx`.
- Tick generator:
  - DIV = CLK_FREQ/(BAUDRATE*OVERSAMPLE), integer division.
  - Counter runs 0..DIV-1 and emits a tick in the cycle it wraps.
  - The counter is forced to 0 in the start-detect cycle.
- Sample counter `s`:
  - Counts 0..OVERSAMPLE-1, incrementing on each tick and wrapping; each wrap is one bit period.
  - Majority vote over samples at s = M-1, M, M+1, where M = OVERSAMPLE/2. The bit value is decided on the M+1 tick.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: `rx` falling edge (prev 1, now 0) → START. This cycle is D. Tick and sample counters are cleared.
  - START: majority = 1 → IDLE (glitch, no output). Majority = 0 → DATA at the end of the bit.
  - DATA: shift decided bits into a shift register, LSB first. After DATA_WIDTH bits → PARITY if PARITY≠0, else STOP.
  - PARITY: compare the decided bit with the computed parity of the data (even: XOR of data; odd: its inverse).
  - STOP: decide each stop bit. At the decision of the last stop bit:
    - load `receive_data`, pulse `ready`, drive the error flags for that cycle;
    - go to IDLE if no frame error, else WAIT_IDLE.
    - The FSM does not wait for the stop bit's end, allowing resync on the next start edge.
  - WAIT_IDLE: remain until `rx` = 1, then IDLE. This prevents retriggering during a held break.
- Errored frames still load `receive_data` and pulse `ready`. Consumers qualify the data with the flags.
- `parity_err` is always 0 when PARITY = 0.
- Reset mid-frame: the next cycle is IDLE. Partial data is discarded and no `ready` is produced.
- Falling edges on `rx` are ignored in every state except IDLE.

## Timing
- Reset values:
  - `receive_data` = 0.
  - `ready`, `parity_err`, `frame_err`, `break_det`, `busy` = 0.
  - FSM in IDLE, counters at 0.
- Raw `line` to `rx` latency: 2 clocks. D is the first cycle in which the edge logic sees `rx` = 0.
- `busy` goes high in cycle D+1.
- NBITS = 1 + DATA_WIDTH + (PARITY≠0) + STOP_BIT_SIZE.
- `ready` is high for exactly one cycle, at D + DIV·((NBITS−1)·OVERSAMPLE + M + 2) + 1.
- `busy` falls in the same cycle as `ready`, or stays high while in WAIT_IDLE.
- `receive_data` is stable from the `ready` cycle until the next `ready`.
- Flags are valid only in the `ready` cycle and are 0 otherwise.
- No back-pressure: a consumer must sample in the `ready` cycle.
- Clock error tolerance: ±(M−1)/OVERSAMPLE of a bit across the whole frame.

## Test plan
Parameters: CLK_FREQ=1600000, BAUDRATE=10000, OVERSAMPLE=16 (DIV=10, 160 clk/bit). Timing is as defined under Timing.
1. 8N1, send 0xA5 → one `ready` pulse at D+1541; `receive_data`=0xA5; all flags 0; `busy` 0 afterward.
2. 8E1, send 0x3C with correct parity, then 0x3C with the parity bit flipped → first frame: `parity_err`=0. Second frame: `parity_err`=1 with `receive_data`=0x3C.
3. 8N1, 3-clk low glitch on idle line, then 0x55 → no `ready` from the glitch; the 0x55 frame is received cleanly.
4. 8N1, 0x81 with stop bit 0, followed by line held high → `frame_err`=1, `receive_data`=0x81; the FSM passes through WAIT_IDLE; the next frame 0x7E is received cleanly.
5. 8N2, line held low for 30 bit times → exactly one `ready` with `break_det`=1, `frame_err`=1, data 0x00; no further `ready` until the line returns high and a new frame 0x11 arrives.
6. 8N1, `reset` asserted for 1 clk mid-data of 0xF0, then 0x0F sent → no `ready` for the aborted frame; 0x0F is received cleanly; all outputs 0 in the cycle after reset.
